// File: rtl/qsys_pkg.sv
// Shared constants and helpers for the qsys slave/master traffic blocks.
package qsys_pkg;

    localparam int QSYS_CNT_W = 16;

    function automatic int qsys_addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/qsys_rd_pipe.sv
// Fixed-latency valid/data delay line for read responses.
module qsys_rd_pipe #(
    parameter int LAT = 2,
    parameter int W   = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           vld_i,
    input  logic [W-1:0]   data_i,
    output logic [LAT-1:0] vld_o,
    output logic [W-1:0]   data_o
);

    logic [LAT-1:0]        vld_q;
    logic [LAT-1:0][W-1:0] data_q;

    // Data only advances with its valid bit, so the last stage holds between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            data_q <= '0;
        end else begin
            vld_q[0] <= vld_i;
            if (vld_i) data_q[0] <= data_i;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) data_q[i] <= data_q[i-1];
            end
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q[LAT-1];

endmodule

// File: rtl/qsys_slave_mem.sv
// Avalon-MM slave with a small word memory, fixed-latency reads, pending-read
// backpressure and saturating per-direction transaction counters.
module qsys_slave_mem
    import qsys_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH        = 16,
    parameter int READ_LATENCY = 2,
    parameter int MAX_PENDING  = 2,
    parameter int NUM_TXNS     = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      writedata,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  write,
    input  logic                  read,
    output logic [WIDTH-1:0]      readdata,
    output logic                  readdatavalid,
    output logic                  waitrequest,
    output logic [QSYS_CNT_W-1:0] rd_count,
    output logic [QSYS_CNT_W-1:0] wr_count,
    output logic                  err,
    output logic                  done
);

    localparam int AW = qsys_addr_w(DEPTH);
    localparam int PW = $clog2(MAX_PENDING + 1);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [READ_LATENCY-1:0]     vld_pipe;
    logic [PW-1:0]               pend_q, pend_d;
    logic [QSYS_CNT_W-1:0]       rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic                        err_q, err_d, done_q, done_d;
    logic [QSYS_CNT_W:0]         total_d;
    logic                        acc_wr, acc_rd, retire;
    logic [AW-1:0]               idx;
    logic                        unused_addr;

    assign idx         = address[AW-1:0];
    assign unused_addr = ^address;
    assign waitrequest = (pend_q == PW'(MAX_PENDING));
    assign acc_wr      = write & ~waitrequest;
    assign acc_rd      = read & ~write & ~waitrequest;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        mem_q      <= '0;
        else if (acc_wr) mem_q[idx] <= writedata;
    end

    qsys_rd_pipe #(
        .LAT (READ_LATENCY),
        .W   (WIDTH)
    ) u_rd_pipe (
        .clk    (clk),
        .rst_n  (rst),
        .vld_i  (acc_rd),
        .data_i (mem_q[idx]),
        .vld_o  (vld_pipe),
        .data_o (readdata)
    );

    assign readdatavalid = vld_pipe[READ_LATENCY-1];

    // A read stops counting as pending on the edge that presents it on readdatavalid.
    generate
        if (READ_LATENCY == 1) begin : g_ret_direct
            assign retire = acc_rd;
        end else begin : g_ret_pipe
            assign retire = vld_pipe[READ_LATENCY-2];
        end
    endgenerate

    always_comb begin
        pend_d = pend_q;
        if (acc_rd && !retire)      pend_d = pend_q + PW'(1);
        else if (!acc_rd && retire) pend_d = pend_q - PW'(1);

        rd_cnt_d = rd_cnt_q;
        if (acc_rd && rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + QSYS_CNT_W'(1);
        wr_cnt_d = wr_cnt_q;
        if (acc_wr && wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + QSYS_CNT_W'(1);

        err_d   = err_q | (write & read & ~waitrequest);
        total_d = {1'b0, rd_cnt_d} + {1'b0, wr_cnt_d};
        done_d  = done_q | (total_d >= (QSYS_CNT_W+1)'(NUM_TXNS));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q   <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
    assign err      = err_q;
    assign done     = done_q;

endmodule

// File: tb/tb_qsys_slave_mem.sv
// Bench for qsys_slave_mem: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_qsys_slave_mem;

    localparam int RL  = 2;
    localparam int MP  = 1;
    localparam int NTX = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] address = '0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [31:0] readdata;
    logic        readdatavalid, waitrequest, err, done;
    logic [15:0] rd_count, wr_count;

    qsys_slave_mem #(
        .WIDTH(32), .ADDR_WIDTH(32), .DEPTH(16),
        .READ_LATENCY(RL), .MAX_PENDING(MP), .NUM_TXNS(NTX)
    ) dut (
        .clk(clk), .rst(rst), .writedata(writedata), .address(address),
        .write(write), .read(read), .readdata(readdata),
        .readdatavalid(readdatavalid), .waitrequest(waitrequest),
        .rd_count(rd_count), .wr_count(wr_count), .err(err), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: responses are scheduled by the edge number they become visible.
    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } rsp_t;

    rsp_t        q[$];
    logic [31:0] mmem[16];
    int unsigned cyc = 0;
    int          m_rd, m_wr;
    bit          m_err, m_done, m_acc, m_wait, e_rdv;
    logic [31:0] m_last;

    task automatic model_clear();
        q.delete();
        foreach (mmem[i]) mmem[i] = '0;
        m_rd = 0; m_wr = 0; m_err = 0; m_done = 0; m_acc = 0; m_last = '0;
    endtask

    initial model_clear();
    always @(negedge rst) model_clear();

    always @(posedge clk) begin
        if (rst) begin
            m_wait = (q.size() == MP);
            cyc++;
            m_acc = (write || read) && !m_wait;
            if (!m_wait) begin
                if (write) begin
                    mmem[address[3:0]] = writedata;
                    if (m_wr < 65535) m_wr++;
                    if (read) m_err = 1;
                end else if (read) begin
                    q.push_back('{cyc + RL - 1, mmem[address[3:0]]});
                    if (m_rd < 65535) m_rd++;
                end
                if (m_rd + m_wr >= NTX) m_done = 1;
            end
        end
    end

    always @(negedge clk) begin
        e_rdv = (q.size() > 0) && (q[0].due == cyc);
        if (e_rdv) begin
            m_last = q[0].data;
            void'(q.pop_front());
        end
        chk("readdatavalid", readdatavalid, e_rdv);
        chk("readdata", readdata, m_last);
        chk("waitrequest", waitrequest, q.size() == MP);
        chk("rd_count", rd_count, m_rd);
        chk("wr_count", wr_count, m_wr);
        chk("err", err, m_err);
        chk("done", done, m_done);
    end

    task automatic issue(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
        int n;
        @(negedge clk);
        write = w; read = r; address = a; writedata = d;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!m_acc && n < 20);
        if (!m_acc) chk("accept_timeout", 0, 1);
        write = 0; read = 0;
    endtask

    task automatic read_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
        issue(0, 1, a, 0);
        @(posedge clk); #1;
        chk({nm, "_rdv"}, readdatavalid, 1);
        chk({nm, "_data"}, readdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_readdata", readdata, 0);
        chk("rst_rdv", readdatavalid, 0);
        chk("rst_wait", waitrequest, 0);
        chk("rst_done", done, 0);
        @(negedge clk); rst = 1;

        issue(1, 0, 32'd3, 32'hDEADBEEF);
        read_chk("wr_rd", 32'd3, 32'hDEADBEEF);
        chk("wr_rd_wrcnt", wr_count, 1);
        chk("wr_rd_rdcnt", rd_count, 1);

        issue(1, 0, 32'h13, 32'h11);
        read_chk("alias", 32'd3, 32'h11);
        chk("done_before_5th", done, 0);

        issue(1, 1, 32'd5, 32'hA5A5);
        chk("proto_err", err, 1);
        chk("proto_rdcnt", rd_count, 2);
        chk("done_at_5th", done, 1);
        issue(1, 0, 32'd8, 32'h1);
        issue(1, 0, 32'd9, 32'h2);
        chk("done_sticky", done, 1);
        chk("wrcnt_after", wr_count, 5);
        read_chk("proto_mem", 32'd5, 32'hA5A5);

        // Reads held high: one acceptance every two cycles with MAX_PENDING=1.
        @(negedge clk); read = 1; address = 32'd9;
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i == 7) read = 0;
            if (readdatavalid) nv++;
        end
        chk("bp_responses", nv, 4);
        chk("bp_rdcnt", rd_count, 7);

        issue(0, 1, 32'd3, 0);
        #2 rst = 0;
        #1;
        chk("mid_rst_rdv", readdatavalid, 0);
        chk("mid_rst_data", readdata, 0);
        chk("mid_rst_rdcnt", rd_count, 0);
        chk("mid_rst_done", done, 0);
        repeat (2) @(negedge clk);
        rst = 1;
        nv = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (readdatavalid) nv++;
        end
        chk("post_rst_rdv", nv, 0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!((write || read) && !m_acc)) begin
                case ($urandom_range(0, 19))
                    0, 1, 2, 3, 4, 5, 6:    begin write = 1; read = 0; end
                    7, 8, 9, 10, 11, 12, 13: begin write = 0; read = 1; end
                    14:                     begin write = 1; read = 1; end
                    default:                begin write = 0; read = 0; end
                endcase
                address   = $urandom;
                writedata = $urandom;
            end
        end
        @(negedge clk); write = 0; read = 0;
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/qsys_slave_mem.md
# qsys_slave_mem

Avalon-MM (Qsys) slave endpoint with a small on-chip word memory, fixed-latency pipelined reads and credit-style backpressure. It is the responder at the far end of the traffic generated by `qsys_master` and terminates its write/read requests for NoC and physical performance evaluation. Per-direction transaction counters and a sticky `done` flag support run completion detection.

## Interface
Parameters:
- `WIDTH`, 32: data width.
- `ADDR_WIDTH`, 32: address width; only the low `$clog2(DEPTH)` bits are decoded.
- `DEPTH`, 16: memory words; power of two, at least 2.
- `READ_LATENCY`, 2: cycles from read acceptance to `readdatavalid`; at least 1.
- `MAX_PENDING`, 2: maximum reads in flight; range 1 to `READ_LATENCY`.
- `NUM_TXNS`, 100: accepted transactions (reads plus writes) that raise `done`.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `writedata`, in, `WIDTH`: write data.
- `address`, in, `ADDR_WIDTH`: word address.
- `write`, in, 1: write request.
- `read`, in, 1: read request.
- `readdata`, out, `WIDTH`: read response data.
- `readdatavalid`, out, 1: `readdata` valid this cycle.
- `waitrequest`, out, 1: request stall.
- `rd_count`, out, 16: accepted reads, saturating.
- `wr_count`, out, 16: accepted writes, saturating.
- `err`, out, 1: sticky protocol error.
- `done`, out, 1: sticky completion flag.

## Operation
- **Reset (`rst`=0):**
  - Memory, read pipeline, pending count, counters, `err` and `done` clear to 0.
  - `readdata`=0, `readdatavalid`=0, `waitrequest`=0.
- **Acceptance:** a request is accepted on a rising edge where it is high and `waitrequest` is low. A request held during `waitrequest` is not accepted; the master must hold it stable.
- **Write:** on the accepting edge, `mem[address[AW-1:0]]` is updated with `writedata`.
- **Read:**
  - On the accepting edge, `mem[address[AW-1:0]]` is captured into stage 0 of a `READ_LATENCY`-deep valid/data shift pipeline.
  - Responses return in acceptance order.
- **Simultaneous `write` and `read`:** the write is performed, the read is dropped (no response, not counted), and `err` sets.
- **Pending count:**
  - +1 on an accepted read; -1 on a cycle with `readdatavalid`.
  - Both in the same cycle: unchanged.
- **`waitrequest`:** equals (pending count == `MAX_PENDING`). It is derived from registers only, with no combinational path from inputs. It applies to both reads and writes.
- **Counters:**
  - `rd_count` and `wr_count` increment on accepted reads and writes; each saturates at 16'hFFFF.
  - `done` sets on the edge where `rd_count + wr_count` first reaches `NUM_TXNS`.
  - `done` stays high until reset; counting continues after `done`.
- **Reset mid-operation:** in-flight reads are discarded, with no `readdatavalid` after reset release.

## Timing
- **Read latency:** read accepted at edge E → `readdatavalid`=1 with data for exactly one cycle, starting at edge E+`READ_LATENCY`-1 plus one register stage. Equivalently, it appears in the `READ_LATENCY`-th cycle after the acceptance cycle. `READ_LATENCY`=1 means the very next cycle.
- **Throughput:**
  - Back-to-back reads are accepted every cycle while pending < `MAX_PENDING`.
  - With `MAX_PENDING`=`READ_LATENCY`, sustained throughput is one read per cycle with no stall.
- **Read-after-write:** a read of a written address, accepted at the edge after the write, returns the new data.
- **`readdata` when idle:** holds its last value while `readdatavalid`=0.
- **`waitrequest` timing:** rises in the cycle after the accepting edge that fills the pending count. It falls in the cycle after the edge where a response retires without a new acceptance.

## Structure
- Package `qsys_pkg`:
  - Counter width constant `QSYS_CNT_W`=16.
  - Function for the decoded address width (`$clog2(DEPTH)`).
  - Shared with `qsys_master` benches.
- Sub-module `qsys_rd_pipe`: parameterised `READ_LATENCY`-stage valid/data delay line with asynchronous active-low clear. The top level holds memory, acceptance logic, pending counter, counters and flags.

## Test plan
- **Write/read:** reset, write 0xDEADBEEF to addr 3, then read addr 3 → `readdatavalid` 2 cycles after acceptance with 0xDEADBEEF; `wr_count`=1, `rd_count`=1.
- **Aliasing:** write 0x11 to addr 0x13 with `DEPTH`=16, then read addr 3 → 0x11.
- **Backpressure:** `MAX_PENDING`=1, `READ_LATENCY`=2, reads held high for 4 requests → `waitrequest` alternates so one read is accepted every 2 cycles; 4 in-order responses; pending never exceeds 1.
- **Protocol error:** `write` and `read` both high → memory written, no response, `err`=1, `rd_count` unchanged.
- **Completion:** `NUM_TXNS`=5, issue 3 writes and 2 reads → `done` rises on the 5th accepting edge and stays high after 2 more writes.
- **Reset mid-read:** reset asserted asynchronously between read acceptance and response → all outputs 0 immediately; no `readdatavalid` after release.
